// File: rtl/decode_pkg.sv
// Shared encodings for decode_stage_pipe: operand-A selects, opcodes and immediate generation.
// imm_gen yields the 32-bit sign-extended immediate; the decode stage widens it to XLEN.
package decode_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_PC   = 2'b01,
    OPA_PC4  = 2'b10,
    OPA_ZERO = 2'b11
  } op_a_sel_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  function automatic imm_type_e imm_type(input logic [6:0] opcode);
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  function automatic logic [INSTR_W-1:0] imm_gen(input logic [INSTR_W-1:0] instr);
    logic [INSTR_W-1:0] imm;
    imm = '0;
    case (imm_type(instr[6:0]))
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file: combinational reads with same-cycle write-through,
// synchronous write, x0 hardwired to zero.
module regfile_2r1w
  import decode_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic [RAW-1:0]  i_rs1_addr,
  input  logic [RAW-1:0]  i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_wr_en,
  input  logic [RAW-1:0]  i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data
);

  logic [XLEN-1:0] r_mem [NREG];

  logic w_wr_ok;
  logic w_rs1_ok;
  logic w_rs2_ok;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_wr_ok   = i_wr_en && (i_wr_addr != '0) && (int'(i_wr_addr) < NREG);
  assign w_rs1_ok  = (i_rs1_addr != '0) && (int'(i_rs1_addr) < NREG);
  assign w_rs2_ok  = (i_rs2_addr != '0) && (int'(i_rs2_addr) < NREG);
  assign w_rs1_hit = w_wr_ok && (i_wr_addr == i_rs1_addr);
  assign w_rs2_hit = w_wr_ok && (i_wr_addr == i_rs2_addr);

  // NOTE: the array has no reset; clearing it would cost a reset net per bit and software never reads an unwritten register.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rs1_data = !w_rs1_ok ? '0 : (w_rs1_hit ? i_wr_data : r_mem[i_rs1_addr]);
  assign o_rs2_data = !w_rs2_ok ? '0 : (w_rs2_hit ? i_wr_data : r_mem[i_rs2_addr]);

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with ID/EX register, MEM/WB forwarding and load-use stall.
// Define DECODE_FWD_EN to forward from MEM; otherwise RAW hazards on EX/MEM producers stall.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int PC_INC = 4,
  localparam int RAW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic [1:0]      op_a_sel,
  input  logic            op_b_sel,
  input  logic            rd_wr_en,
  input  logic            is_load,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            mem_wr_en,
  input  logic [RAW-1:0]  mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wr_en,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RAW-1:0]  ex_rd,
  output logic            ex_wr_en,
  output logic            ex_is_load
);

  logic [RAW-1:0]  w_rs1;
  logic [RAW-1:0]  w_rs2;
  logic [RAW-1:0]  w_rd;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rf_rs1;
  logic [XLEN-1:0] w_rf_rs2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  op_a_sel_e       w_opa_sel;
  logic            w_load_use;
  logic            w_hazard;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_pc;
  logic [XLEN-1:0] r_ex_op_a;
  logic [XLEN-1:0] r_ex_op_b;
  logic [XLEN-1:0] r_ex_rs2_data;
  logic [XLEN-1:0] r_ex_imm;
  logic [RAW-1:0]  r_ex_rd;
  logic            r_ex_wr_en;
  logic            r_ex_is_load;

  assign w_rs1     = RAW'(if_instr[19:15]);
  assign w_rs2     = RAW'(if_instr[24:20]);
  assign w_rd      = RAW'(if_instr[11:7]);
  assign w_imm     = XLEN'($signed(imm_gen(if_instr)));
  assign w_opa_sel = op_a_sel_e'(op_a_sel);

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk        (clk),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rf_rs1),
    .o_rs2_data (w_rf_rs2),
    .i_wr_en    (wb_wr_en),
    .i_wr_addr  (wb_rd),
    .i_wr_data  (wb_data)
  );

  assign w_load_use = r_ex_valid && r_ex_is_load && (r_ex_rd != '0) &&
                      ((r_ex_rd == w_rs1) || (r_ex_rd == w_rs2));

`ifdef DECODE_FWD_EN
  // The register file already returns 0 for x0 and applies WB write-through; MEM overrides it.
  assign w_rs1_val = (w_rs1 == '0) ? '0 : ((mem_wr_en && mem_rd == w_rs1) ? mem_data : w_rf_rs1);
  assign w_rs2_val = (w_rs2 == '0) ? '0 : ((mem_wr_en && mem_rd == w_rs2) ? mem_data : w_rf_rs2);
  assign w_hazard  = w_load_use;
`else
  logic w_ex_raw;
  logic w_mem_raw;
  logic w_unused_mem;

  assign w_rs1_val    = w_rf_rs1;
  assign w_rs2_val    = w_rf_rs2;
  assign w_unused_mem = ^mem_data;
  assign w_ex_raw     = r_ex_valid && r_ex_wr_en && (r_ex_rd != '0) &&
                        ((r_ex_rd == w_rs1) || (r_ex_rd == w_rs2));
  assign w_mem_raw    = mem_wr_en && (mem_rd != '0) &&
                        ((mem_rd == w_rs1) || (mem_rd == w_rs2));
  assign w_hazard     = w_load_use || w_ex_raw || w_mem_raw;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_op_a = '0;
    case (w_opa_sel)
      OPA_RS1:  w_op_a = w_rs1_val;
      OPA_PC:   w_op_a = if_pc;
      OPA_PC4:  w_op_a = if_pc + XLEN'(PC_INC);
      OPA_ZERO: w_op_a = '0;
      default:  w_op_a = '0;
    endcase
  end

  assign w_op_b   = op_b_sel ? w_imm : w_rs2_val;
  assign id_ready = ex_ready && !w_hazard && !rst;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_op_a     <= '0;
      r_ex_op_b     <= '0;
      r_ex_rs2_data <= '0;
      r_ex_imm      <= '0;
      r_ex_rd       <= '0;
      r_ex_wr_en    <= 1'b0;
      r_ex_is_load  <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (ex_ready && w_hazard) begin
      r_ex_valid <= 1'b0;
      r_ex_wr_en <= 1'b0;
    end else if (ex_ready) begin
      r_ex_valid    <= if_valid;
      r_ex_pc       <= if_pc;
      r_ex_op_a     <= w_op_a;
      r_ex_op_b     <= w_op_b;
      r_ex_rs2_data <= w_rs2_val;
      r_ex_imm      <= w_imm;
      r_ex_rd       <= w_rd;
      r_ex_wr_en    <= rd_wr_en;
      r_ex_is_load  <= is_load;
    end
  end

  // A killed slot may keep a stale write enable internally; never expose it.
  assign ex_valid    = r_ex_valid;
  assign ex_pc       = r_ex_pc;
  assign ex_op_a     = r_ex_op_a;
  assign ex_op_b     = r_ex_op_b;
  assign ex_rs2_data = r_ex_rs2_data;
  assign ex_imm      = r_ex_imm;
  assign ex_rd       = r_ex_rd;
  assign ex_wr_en    = r_ex_wr_en && r_ex_valid;
  assign ex_is_load  = r_ex_is_load;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe; expectations are hand-computed per scenario.
// Branches on DECODE_FWD_EN where forwarding and stall behaviour differ.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  op_a_sel;
  logic        op_b_sel;
  logic        rd_wr_en;
  logic        is_load;
  logic        ex_ready;
  logic        flush;
  logic        mem_wr_en;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_wr_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_wr_en;
  logic        ex_is_load;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.XLEN(32), .NREG(32), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .id_ready(id_ready), .if_pc(if_pc),
    .if_instr(if_instr), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel), .rd_wr_en(rd_wr_en),
    .is_load(is_load), .ex_ready(ex_ready), .flush(flush), .mem_wr_en(mem_wr_en),
    .mem_rd(mem_rd), .mem_data(mem_data), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a),
    .ex_op_b(ex_op_b), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load)
  );

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, 3'b000, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_pc = '0; if_instr = '0; op_a_sel = 2'b00; op_b_sel = 1'b0;
    rd_wr_en = 1'b0; is_load = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    mem_wr_en = 1'b0; mem_rd = '0; mem_data = '0; wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic drain();
    idle();
    tick();
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [1:0] opa,
                       input logic opb, input logic wr, input logic ld);
    if_valid = 1'b1; if_instr = instr; if_pc = pc; op_a_sel = opa; op_b_sel = opb;
    rd_wr_en = wr; is_load = ld;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
    total++; if (ex_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", ex_pc); end
    total++; if (ex_op_a !== 32'h0) begin bad++; $display("FAIL reset_op_a got=%h exp=0", ex_op_a); end
    total++; if (ex_op_b !== 32'h0) begin bad++; $display("FAIL reset_op_b got=%h exp=0", ex_op_b); end
    total++; if (ex_rs2_data !== 32'h0) begin bad++; $display("FAIL reset_rs2 got=%h exp=0", ex_rs2_data); end
    total++; if (ex_imm !== 32'h0) begin bad++; $display("FAIL reset_imm got=%h exp=0", ex_imm); end
    total++; if (ex_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", ex_rd); end
    total++; if (ex_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", ex_wr_en); end
    total++; if (ex_is_load !== 1'b0) begin bad++; $display("FAIL reset_is_load got=%b exp=0", ex_is_load); end
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL reset_id_ready got=%b exp=0", id_ready); end
    rst = 1'b0;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL post_reset_id_ready got=%b exp=1", id_ready); end
  endtask

  task automatic test_basic();
    idle();
    wb_wr_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    tick();
    wb_wr_en = 1'b0;
    issue(enc_i(12'd8, 5'd5, 5'd6, 7'b0010011), 32'h100, 2'b00, 1'b1, 1'b1, 1'b0);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL basic_id_ready got=%b exp=1", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", ex_valid); end
    total++; if (ex_op_a !== 32'h1234) begin bad++; $display("FAIL basic_op_a got=%h exp=00001234", ex_op_a); end
    total++; if (ex_op_b !== 32'h8) begin bad++; $display("FAIL basic_op_b got=%h exp=00000008", ex_op_b); end
    total++; if (ex_rd !== 5'd6) begin bad++; $display("FAIL basic_rd got=%0d exp=6", ex_rd); end
    total++; if (ex_pc !== 32'h100) begin bad++; $display("FAIL basic_pc got=%h exp=00000100", ex_pc); end
    total++; if (ex_imm !== 32'h8) begin bad++; $display("FAIL basic_imm got=%h exp=00000008", ex_imm); end
    total++; if (ex_wr_en !== 1'b1) begin bad++; $display("FAIL basic_wr_en got=%b exp=1", ex_wr_en); end
    total++; if (ex_is_load !== 1'b0) begin bad++; $display("FAIL basic_is_load got=%b exp=0", ex_is_load); end
  endtask

  task automatic test_operands();
    drain();
    wb_wr_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h55;
    tick();
    wb_wr_en = 1'b0;
    issue(enc_r(5'd11, 5'd5, 5'd10), 32'h200, 2'b10, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (ex_op_a !== 32'h204) begin bad++; $display("FAIL opa_pc4 got=%h exp=00000204", ex_op_a); end
    total++; if (ex_op_b !== 32'h55) begin bad++; $display("FAIL opb_rs2 got=%h exp=00000055", ex_op_b); end
    total++; if (ex_rs2_data !== 32'h55) begin bad++; $display("FAIL rs2_data got=%h exp=00000055", ex_rs2_data); end
    total++; if (ex_imm !== 32'h0) begin bad++; $display("FAIL r_type_imm got=%h exp=0", ex_imm); end
    issue(enc_r(5'd12, 5'd5, 5'd10), 32'h208, 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (ex_op_a !== 32'h208) begin bad++; $display("FAIL opa_pc got=%h exp=00000208", ex_op_a); end
    total++; if (ex_rd !== 5'd12) begin bad++; $display("FAIL b2b_rd got=%0d exp=12", ex_rd); end
    issue(enc_i(12'h7FF, 5'd5, 5'd20, 7'b0010011), 32'h20C, 2'b11, 1'b1, 1'b1, 1'b0);
    tick();
    total++; if (ex_op_a !== 32'h0) begin bad++; $display("FAIL opa_zero got=%h exp=0", ex_op_a); end
    total++; if (ex_op_b !== 32'h7FF) begin bad++; $display("FAIL opb_imm_pos got=%h exp=000007ff", ex_op_b); end
    issue(enc_i(12'hFFF, 5'd5, 5'd21, 7'b0010011), 32'h210, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    total++; if (ex_op_a !== 32'h1234) begin bad++; $display("FAIL opa_rs1 got=%h exp=00001234", ex_op_a); end
    total++; if (ex_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL imm_neg got=%h exp=ffffffff", ex_imm); end
  endtask

  task automatic test_fwd_priority();
    drain();
    mem_wr_en = 1'b1; mem_rd = 5'd5; mem_data = 32'hAAAA;
    wb_wr_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hBBBB;
    issue(enc_i(12'd1, 5'd5, 5'd22, 7'b0010011), 32'h300, 2'b00, 1'b1, 1'b1, 1'b0);
    #1;
`ifdef DECODE_FWD_EN
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL prio_id_ready got=%b exp=1", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL prio_valid got=%b exp=1", ex_valid); end
    total++; if (ex_op_a !== 32'hAAAA) begin bad++; $display("FAIL prio_mem_wins got=%h exp=0000aaaa", ex_op_a); end
`else
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL prio_stall got=%b exp=0", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL prio_bubble got=%b exp=0", ex_valid); end
    mem_wr_en = 1'b0; wb_wr_en = 1'b0;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL prio_resume got=%b exp=1", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL prio_valid got=%b exp=1", ex_valid); end
    total++; if (ex_op_a !== 32'hBBBB) begin bad++; $display("FAIL prio_wb_value got=%h exp=0000bbbb", ex_op_a); end
`endif
    drain();
    wb_wr_en = 1'b1; wb_rd = 5'd13; wb_data = 32'h77;
    issue(enc_i(12'd0, 5'd13, 5'd14, 7'b0010011), 32'h310, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    total++; if (ex_op_a !== 32'h77) begin bad++; $display("FAIL wb_write_through got=%h exp=00000077", ex_op_a); end
    wb_wr_en = 1'b0;
  endtask

  task automatic test_load_use();
    drain();
    wb_wr_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h11;
    tick();
    wb_wr_en = 1'b0;
    issue(enc_i(12'd0, 5'd1, 5'd7, 7'b0000011), 32'h400, 2'b00, 1'b1, 1'b1, 1'b1);
    tick();
    total++; if (ex_is_load !== 1'b1) begin bad++; $display("FAIL lw_is_load got=%b exp=1", ex_is_load); end
    total++; if (ex_op_a !== 32'h11) begin bad++; $display("FAIL lw_op_a got=%h exp=00000011", ex_op_a); end
    issue(enc_r(5'd8, 5'd7, 5'd1), 32'h404, 2'b00, 1'b0, 1'b1, 1'b0);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b exp=0", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
    total++; if (ex_wr_en !== 1'b0) begin bad++; $display("FAIL lu_bubble_wr got=%b exp=0", ex_wr_en); end
    mem_wr_en = 1'b1; mem_rd = 5'd7; mem_data = 32'h700;
    #1;
`ifdef DECODE_FWD_EN
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL lu_resume got=%b exp=1", id_ready); end
    tick();
`else
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL lu_mem_stall got=%b exp=0", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble2 got=%b exp=0", ex_valid); end
    mem_wr_en = 1'b0; wb_wr_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h700;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL lu_resume got=%b exp=1", id_ready); end
    tick();
`endif
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL lu_issue got=%b exp=1", ex_valid); end
    total++; if (ex_op_a !== 32'h700) begin bad++; $display("FAIL lu_fwd got=%h exp=00000700", ex_op_a); end
    total++; if (ex_op_b !== 32'h11) begin bad++; $display("FAIL lu_op_b got=%h exp=00000011", ex_op_b); end
    total++; if (ex_rd !== 5'd8) begin bad++; $display("FAIL lu_rd got=%0d exp=8", ex_rd); end
  endtask

  task automatic test_backpressure();
    drain();
    issue(enc_i(12'd3, 5'd5, 5'd15, 7'b0010011), 32'h500, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    total++; if (ex_op_a !== 32'hBBBB) begin bad++; $display("FAIL bp_first_op_a got=%h exp=0000bbbb", ex_op_a); end
    issue(enc_i(12'd5, 5'd13, 5'd16, 7'b0010011), 32'h504, 2'b00, 1'b1, 1'b1, 1'b0);
    ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL bp_id_ready cyc=%0d got=%b exp=0", c, id_ready); end
      tick();
      total++; if (ex_pc !== 32'h500) begin bad++; $display("FAIL bp_hold_pc cyc=%0d got=%h exp=00000500", c, ex_pc); end
      total++; if (ex_op_b !== 32'h3) begin bad++; $display("FAIL bp_hold_op_b cyc=%0d got=%h exp=3", c, ex_op_b); end
      total++; if (ex_rd !== 5'd15 || ex_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_rd cyc=%0d got=%0d/%b exp=15/1", c, ex_rd, ex_valid); end
    end
    ex_ready = 1'b1;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", id_ready); end
    tick();
    total++; if (ex_pc !== 32'h504) begin bad++; $display("FAIL bp_new_pc got=%h exp=00000504", ex_pc); end
    total++; if (ex_op_a !== 32'h77) begin bad++; $display("FAIL bp_new_op_a got=%h exp=00000077", ex_op_a); end
    total++; if (ex_rd !== 5'd16) begin bad++; $display("FAIL bp_new_rd got=%0d exp=16", ex_rd); end
  endtask

  task automatic test_flush_reset();
    issue(enc_i(12'd0, 5'd13, 5'd17, 7'b0010011), 32'h508, 2'b00, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush_id_ready got=%b exp=1", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", ex_valid); end
    total++; if (ex_wr_en !== 1'b0) begin bad++; $display("FAIL flush_wr_en got=%b exp=0", ex_wr_en); end
    total++; if (ex_pc !== 32'h504) begin bad++; $display("FAIL flush_hold_pc got=%h exp=00000504", ex_pc); end
    drain();
    issue(enc_i(12'd0, 5'd1, 5'd7, 7'b0000011), 32'h600, 2'b00, 1'b1, 1'b1, 1'b1);
    tick();
    issue(enc_r(5'd8, 5'd7, 5'd1), 32'h604, 2'b00, 1'b0, 1'b1, 1'b0);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", id_ready); end
    rst = 1'b1;
    tick();
    total++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0) begin bad++; $display("FAIL rst_mid_valid_pc got=%b/%h exp=0/0", ex_valid, ex_pc); end
    total++; if (ex_op_a !== 32'h0 || ex_rd !== 5'd0) begin bad++; $display("FAIL rst_mid_opa_rd got=%h/%0d exp=0/0", ex_op_a, ex_rd); end
    total++; if (ex_is_load !== 1'b0) begin bad++; $display("FAIL rst_mid_is_load got=%b exp=0", ex_is_load); end
    rst = 1'b0;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8) begin bad++; $display("FAIL post_rst_issue got=%b/%0d exp=1/8", ex_valid, ex_rd); end
    total++; if (ex_op_b !== 32'h11) begin bad++; $display("FAIL rf_not_reset got=%h exp=00000011", ex_op_b); end
  endtask

  task automatic test_x0_imm();
    drain();
    wb_wr_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    issue(enc_i(12'd0, 5'd0, 5'd18, 7'b0010011), 32'h700, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    total++; if (ex_op_a !== 32'h0) begin bad++; $display("FAIL x0_write_through got=%h exp=0", ex_op_a); end
    wb_wr_en = 1'b0;
    issue(enc_r(5'd19, 5'd0, 5'd0), 32'h704, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (ex_op_a !== 32'h0 || ex_op_b !== 32'h0) begin bad++; $display("FAIL x0_read got=%h/%h exp=0/0", ex_op_a, ex_op_b); end
    issue(32'hFE000EE3, 32'h708, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    total++; if (ex_imm !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_b got=%h exp=fffffffc", ex_imm); end
    total++; if (ex_op_b !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_b_op_b got=%h exp=fffffffc", ex_op_b); end
    issue(32'h123454B7, 32'h70C, 2'b11, 1'b1, 1'b1, 1'b0);
    tick();
    total++; if (ex_imm !== 32'h12345000) begin bad++; $display("FAIL imm_u got=%h exp=12345000", ex_imm); end
    total++; if (ex_rd !== 5'd9) begin bad++; $display("FAIL lui_rd got=%0d exp=9", ex_rd); end
    issue(enc_s(12'h824, 5'd0, 5'd0), 32'h710, 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    total++; if (ex_imm !== 32'hFFFFF824) begin bad++; $display("FAIL imm_s got=%h exp=fffff824", ex_imm); end
    issue(enc_j(21'h0FF00, 5'd20), 32'h714, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    total++; if (ex_imm !== 32'h0000FF00) begin bad++; $display("FAIL imm_j got=%h exp=0000ff00", ex_imm); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_operands();
    test_fwd_priority();
    test_load_use();
    test_backpressure();
    test_flush_reset();
    test_x0_imm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
